mont_mult_serial: RTL and testbench

- Bit-serial radix-2 Montgomery multiplier. Computes z = x·y·2^-k mod m.
- It is the responder side of the start/done multiply handshake that the modular-exponentiation controller issues for every square, multiply, domain-conversion and final-reduction step.
- Default modulus is the P-192 prime. The block is a drop-in multiply engine for that controller.

---
 rtl/mont_p192_pkg.sv | 27 ++
 rtl/mont_mult_serial_step.sv | 25 ++
 rtl/mont_mult_serial.sv | 91 +++++++++
 tb/tb_mont_mult_serial.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mont_p192_pkg.sv
// Shared constants and types for the P-192 Montgomery multiply engine and
// the modular-exponentiation controller that drives it.
//   K, LOGK   : operand width and iteration-counter width
//   M_P192    : modulus 2^192 - 2^64 - 1
//   MINUS_M   : 2^K - m
//   EXP_K     : 2^K mod m  (Montgomery form of 1)
//   EXP_2K    : 2^2K mod m (domain-conversion factor)
//   ONE       : plain 1, used to leave the Montgomery domain
//   state_e   : multiplier control states
package mont_p192_pkg;

  localparam int unsigned K    = 192;
  localparam int unsigned LOGK = 8;

  localparam logic [K-1:0] M_P192  = 192'hffffffff_ffffffff_ffffffff_fffffffe_ffffffff_ffffffff;
  localparam logic [K-1:0] MINUS_M = 192'h00000000_00000000_00000000_00000001_00000000_00000001;
  localparam logic [K-1:0] EXP_K   = 192'h00000000_00000000_00000000_00000001_00000000_00000001;
  localparam logic [K-1:0] EXP_2K  = 192'h00000000_00000001_00000000_00000002_00000000_00000001;
  localparam logic [K-1:0] ONE     = 192'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2
  } state_e;

endpackage

// File: rtl/mont_mult_serial_step.sv
// Combinational single iteration of radix-2 Montgomery multiplication.
//   acc_i  : running accumulator (k+1 bits, always < 2m)
//   yr_i   : multiplier
//   xbit_i : current multiplicand bit
//   m_i    : odd modulus
//   acc_o  : (acc + xbit*y [+ m if odd]) / 2
module mont_step #(
  parameter int unsigned k = 192
) (
  input  logic [k:0]   acc_i,
  input  logic [k-1:0] yr_i,
  input  logic         xbit_i,
  input  logic [k-1:0] m_i,
  output logic [k:0]   acc_o
);

  logic [k+1:0] t_sum;
  logic [k+1:0] t_even;

  // Partial product add, then make the sum even by adding the odd modulus.
  assign t_sum  = {1'b0, acc_i} + (xbit_i ? {2'b00, yr_i} : '0);
  assign t_even = t_sum[0] ? (t_sum + {2'b00, m_i}) : t_sum;
  assign acc_o  = (k+1)'(t_even >> 1);

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: z = x*y*2^-k mod m.
// Responder side of the controller's start/done multiply handshake.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   x, y  : operands (< m), sampled on the accepting edge only
//   start : request, accepted on any edge while idle
//   z     : result, held until the next completed operation or reset
//   done  : 1 = idle with valid/reset result, 0 = busy
module mont_mult_serial
  import mont_p192_pkg::*;
#(
  parameter int unsigned  k    = K,
  parameter int unsigned  logk = LOGK,
  parameter logic [k-1:0] m    = M_P192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [k-1:0] x,
  input  logic [k-1:0] y,
  input  logic         start,
  output logic [k-1:0] z,
  output logic         done
);

  state_e          state_q;
  logic [k-1:0]    xs_q;
  logic [k-1:0]    yr_q;
  logic [k-1:0]    z_q;
  logic [k:0]      acc_q;
  logic [k:0]      acc_d;
  logic [k:0]      acc_sub;
  logic [logk-1:0] cnt_q;
  logic            done_q;

  mont_step #(.k(k)) u_step (
    .acc_i  (acc_q),
    .yr_i   (yr_q),
    .xbit_i (xs_q[0]),
    .m_i    (m),
    .acc_o  (acc_d)
  );

  // Final conditional subtraction; acc < 2m so one subtract suffices.
  assign acc_sub = acc_q - {1'b0, m};

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      yr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xs_q    <= x;
            yr_q    <= y;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          xs_q  <= xs_q >> 1;
          cnt_q <= cnt_q + logk'(1);
          if (cnt_q == logk'(k - 1)) begin
            state_q <= CORR;
          end
        end
        CORR: begin
          z_q     <= (acc_q >= {1'b0, m}) ? k'(acc_sub) : k'(acc_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign z    = z_q;
  assign done = done_q;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Self-checking bench for mont_mult_serial: a k=8/m=241 instance and a
// default P-192 instance driven by directed and random operations, checked
// each cycle against an arithmetic reference plus literal expectations.
module tb_mont_mult_serial;
  import mont_p192_pkg::*;

  localparam logic [7:0] M8 = 8'd241;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start8, start192;
  logic [7:0]   x8, y8, z8;
  logic [191:0] x192, y192, z192;
  logic         done8, done192;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mont_mult_serial #(.k(8), .logk(4), .m(M8)) dut8 (
    .clk(clk), .reset(rst_n), .x(x8), .y(y8), .start(start8), .z(z8), .done(done8)
  );

  mont_mult_serial dut192 (
    .clk(clk), .reset(rst_n), .x(x192), .y(y192), .start(start192), .z(z192), .done(done192)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: x*y*2^-k mod m, with 2^-k built as ((m+1)/2)^k mod m.
  function automatic logic [191:0] golden(input logic [191:0] a, input logic [191:0] b,
                                          input logic [191:0] mod, input int kk);
    logic [383:0] mm, h, r, p;
    mm = {192'b0, mod};
    h  = (mm + 384'd1) >> 1;
    r  = 384'd1;
    for (int i = 0; i < kk; i++) r = (r * h) % mm;
    p = ({192'b0, a} * {192'b0, b}) % mm;
    p = (p * r) % mm;
    return p[191:0];
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done8 : done192;
  endfunction

  function automatic logic [191:0] cur_z(input int sel);
    return (sel == 0) ? {184'b0, z8} : z192;
  endfunction

  // Cycle-level behavioural model and per-cycle compare for both instances.
  logic         m_busy [2];
  int           m_rem  [2];
  logic [191:0] m_pend [2];
  logic [191:0] m_z    [2];

  initial begin
    logic         s   [2];
    logic [191:0] a   [2];
    logic [191:0] b   [2];
    logic [191:0] mod [2];
    int           kk  [2];
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_rem[i] = 0; m_pend[i] = '0; m_z[i] = '0;
    end
    mod[0] = {184'b0, M8}; kk[0] = 8;
    mod[1] = M_P192;       kk[1] = 192;
    forever begin
      @(posedge clk);
      s[0] = start8;   a[0] = {184'b0, x8}; b[0] = {184'b0, y8};
      s[1] = start192; a[1] = x192;         b[1] = y192;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_busy[i] = 1'b0; m_z[i] = '0;
        end else if (!m_busy[i] && s[i]) begin
          m_busy[i] = 1'b1;
          m_rem[i]  = kk[i] + 1;
          m_pend[i] = golden(a[i], b[i], mod[i], kk[i]);
        end else if (m_busy[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_busy[i] = 1'b0;
            m_z[i]    = m_pend[i];
          end
        end
      end
      #2;
      check("cyc_done8",   {191'b0, done8},   {191'b0, ~m_busy[0]});
      check("cyc_z8",      {184'b0, z8},      m_z[0]);
      check("cyc_done192", {191'b0, done192}, {191'b0, ~m_busy[1]});
      check("cyc_z192",    z192,              m_z[1]);
    end
  end

  // One handshake from idle; returns result and edges from accept to done.
  task automatic run_op(input int sel, input logic [191:0] xa, input logic [191:0] ya,
                        output logic [191:0] zr, output int lat);
    @(posedge clk); #1;
    if (sel == 0) begin
      start8 = 1'b1; x8 = xa[7:0]; y8 = ya[7:0];
    end else begin
      start192 = 1'b1; x192 = xa; y192 = ya;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start192 = 1'b0;
    check("done_fall", {191'b0, cur_done(sel)}, 192'd0);
    lat = 0;
    while (!cur_done(sel) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_timeout", {191'b0, cur_done(sel)}, 192'd1);
    zr = cur_z(sel);
  endtask

  function automatic logic [191:0] rand192();
    logic [191:0] v;
    do begin
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end while (v >= M_P192);
    return v;
  endfunction

  initial begin
    logic [191:0] zr;
    int           lat;
    int           rises;
    logic         prev;

    rst_n = 1'b0; start8 = 1'b0; start192 = 1'b0;
    x8 = '0; y8 = '0; x192 = '0; y192 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z8",      {184'b0, z8},      192'd0);
    check("rst_done8",   {191'b0, done8},   192'd1);
    check("rst_z192",    z192,              192'd0);
    check("rst_done192", {191'b0, done192}, 192'd1);
    rst_n = 1'b1;

    run_op(0, 192'd15, 192'd100, zr, lat);
    check("k8_r_times_100", zr, 192'd100);
    check("k8_latency", 192'(lat), 192'd9);
    run_op(0, 192'd1, 192'd1, zr, lat);
    check("k8_rinv", zr, 192'd225);
    run_op(0, 192'd240, 192'd240, zr, lat);
    check("k8_max", zr, 192'd225);

    run_op(1, EXP_K, EXP_2K, zr, lat);
    check("p192_r_r2", zr, EXP_2K);
    check("p192_latency", 192'(lat), 192'd193);
    run_op(1, ONE, EXP_2K, zr, lat);
    check("p192_one_r2", zr, EXP_K);
    run_op(1, 192'd0, 192'd0, zr, lat);
    check("p192_zero", zr, 192'd0);
    run_op(1, M_P192 - 192'd1, M_P192 - 192'd1, zr, lat);
    check("p192_max_nonzero", {191'b0, zr != 192'd0}, 192'd1);

    // Abort at CALC iteration 50.
    @(posedge clk); #1;
    start192 = 1'b1; x192 = EXP_K; y192 = EXP_2K;
    @(posedge clk); #1;
    start192 = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    check("abort_busy", {191'b0, done192}, 192'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_done", {191'b0, done192}, 192'd1);
    check("abort_z",    z192,              192'd0);
    rst_n = 1'b1;
    run_op(1, EXP_K, EXP_2K, zr, lat);
    check("after_abort", zr, EXP_2K);

    // Start pulses and operand changes while busy are ignored.
    @(posedge clk); #1;
    start8 = 1'b1; x8 = 8'd15; y8 = 8'd100;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      start8 = (i % 2 == 0);
      x8 = 8'($urandom); y8 = 8'($urandom);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("busy_ignore", {184'b0, z8}, 192'd100);

    // Start held high: 1000 back-to-back random operations, one per 10 edges.
    @(posedge clk); #1;
    start8 = 1'b1;
    x8 = 8'($urandom_range(240, 0)); y8 = 8'($urandom_range(240, 0));
    rises = 0;
    prev  = done8;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      if (done8 && !prev) rises++;
      prev = done8;
      x8 = 8'($urandom_range(240, 0)); y8 = 8'($urandom_range(240, 0));
    end
    start8 = 1'b0;
    check("b2b_count", 192'(rises), 192'd1000);

    // A few random P-192 operations.
    for (int n = 0; n < 4; n++) begin
      run_op(1, rand192(), rand192(), zr, lat);
      check("p192_rand_lt_m", {191'b0, zr < M_P192}, 192'd1);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
